// File: rtl/mfu_pkg.sv
// Shared types for the mFU accumulate/drain slice.
// MFU_ACC_SAT_EN selects saturating accumulation in mfu_acc_drain.
package mfu_pkg;

    localparam int P_W = 16;

    typedef enum logic [1:0] {
        MODE_8X8  = 2'd0,
        MODE_4X4  = 2'd1,
        MODE_2X2  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [P_W-1:0] sext8(input logic [7:0] b);
        return {{(P_W-8){b[7]}}, b};
    endfunction

    function automatic logic [P_W-1:0] sext4(input logic [3:0] n);
        return {{(P_W-4){n[3]}}, n};
    endfunction

endpackage

// File: rtl/mfu_unpack.sv
// Folds one mFU product into its signed sub-product sum
// according to the precision mode it was issued with.
module mfu_unpack
    import mfu_pkg::*;
(
    input  logic [1:0]     mode,
    input  logic [P_W-1:0] p,
    output logic [P_W-1:0] s
);

    always_comb begin
        s = '0;
        unique case (mode_e'(mode))
            MODE_8X8:  s = p;
            MODE_4X4:  s = sext8(p[15:8]) + sext8(p[7:0]);
            MODE_2X2:  s = sext4(p[15:12]) + sext4(p[11:8])
                         + sext4(p[7:4]) + sext4(p[3:0]);
            MODE_RSVD: s = '0;
        endcase
    end

endmodule

// File: rtl/mfu_acc_drain.sv
// Dot-product accumulator behind the mFU with a one-entry result drain.
// Define MFU_ACC_SAT_EN for saturating adds with a sticky ovf flag.
module mfu_acc_drain
    import mfu_pkg::*;
#(
    parameter int LAT   = 1,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [7:0]       len,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [15:0]      p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy,
    output logic             ovf
);

    localparam int CNT_W = 9;

    state_e state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [LAT-1:0] vpipe_q, vpipe_d;
    logic [LAT-1:0][1:0] mpipe_q, mpipe_d;

    logic             v_dly;
    logic [1:0]       mode_dly;
    logic [P_W-1:0]   s;
    logic [ACC_W-1:0] s_ext;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_inc;

    // Delay line keeps running across jobs so products issued with start count.
    always_comb begin
        vpipe_d = '0;
        mpipe_d = '0;
        vpipe_d[0] = in_valid;
        mpipe_d[0] = mode;
        for (int i = 1; i < LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
            mpipe_d[i] = mpipe_q[i-1];
        end
    end

    assign v_dly    = vpipe_q[LAT-1];
    assign mode_dly = mpipe_q[LAT-1];

    mfu_unpack u_unpack (
        .mode (mode_dly),
        .p    (p),
        .s    (s)
    );

    assign s_ext   = {{(ACC_W-P_W){s[P_W-1]}}, s};
    assign cnt_inc = cnt_q + 9'd1;

`ifdef MFU_ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide;
    logic           clip;
    logic           ovf_q, ovf_d;

    always_comb begin
        wide = {acc_q[ACC_W-1], acc_q} + {s_ext[ACC_W-1], s_ext};
        clip = wide[ACC_W] ^ wide[ACC_W-1];
        acc_sum = wide[ACC_W-1:0];
        if (clip) begin
            acc_sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    assign ovf = ovf_q;
`else
    assign acc_sum = acc_q + s_ext;
    assign ovf     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
`ifdef MFU_ACC_SAT_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    acc_d   = '0;
                    cnt_d   = '0;
                    tgt_d   = (len == 8'd0) ? 9'd256 : {1'b0, len};
`ifdef MFU_ACC_SAT_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (v_dly) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
`ifdef MFU_ACC_SAT_EN
                    ovf_d = ovf_q | clip;
`endif
                    if (cnt_inc == tgt_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            tgt_q   <= '0;
            vpipe_q <= '0;
            mpipe_q <= '0;
`ifdef MFU_ACC_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            vpipe_q <= vpipe_d;
            mpipe_q <= mpipe_d;
`ifdef MFU_ACC_SAT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = acc_q;

endmodule

// File: tb/tb_mfu_acc_drain.sv
// Randomized bench for mfu_acc_drain against a job-level reference model.
// Honors MFU_ACC_SAT_EN to pick the saturating or wrapping expectation.
module tb_mfu_acc_drain;

    localparam int LAT   = 2;
    localparam int ACC_W = 20;
    localparam longint HALF = longint'(1) << (ACC_W - 1);
    localparam longint FULL = HALF * 2;
    localparam longint MAXV = HALF - 1;
    localparam longint MINV = -HALF;

    logic             clk;
    logic             nrst;
    logic             start;
    logic [7:0]       len;
    logic             in_valid;
    logic [1:0]       mode;
    logic [15:0]      p;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             busy;
    logic             ovf;

    mfu_acc_drain #(.LAT(LAT), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .mode      (mode),
        .p         (p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: 0 idle, 1 collecting, 2 holding a result
    int     mst;
    longint macc;
    int     mcnt;
    int     mneed;
    bit     movf;
    logic        va [0:LAT];
    logic [1:0]  ma [0:LAT];
    logic [15:0] pa [0:LAT];
    longint last_acc;
    int     n_acc;
    logic [15:0] prods [$];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sub_sum(input logic [1:0] m, input logic [15:0] pv);
        longint r;
        int n;
        r = 0;
        case (m)
            2'd0: r = longint'($signed(pv));
            2'd1: r = longint'($signed(pv[15:8])) + longint'($signed(pv[7:0]));
            2'd2: begin
                for (int i = 0; i < 4; i++) begin
                    n = int'((pv >> (4 * i)) & 16'hF);
                    if (n > 7) n -= 16;
                    r += n;
                end
            end
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic longint sdata();
        return longint'($signed(out_data));
    endfunction

    task automatic model_clear();
        mst = 0; macc = 0; mcnt = 0; mneed = 0; movf = 0;
        for (int i = 0; i <= LAT; i++) begin
            va[i] = 1'b0; ma[i] = 2'd0; pa[i] = 16'd0;
        end
    endtask

    task automatic step(input bit st, input int ln, input bit v,
                        input logic [1:0] m, input logic [15:0] pv, input bit rdy);
        longint t;
        chk("out_valid", out_valid, longint'(mst == 2));
        chk("busy", busy, longint'(mst != 0));
        chk("ovf", ovf, longint'(movf));
        if (mst == 2) chk("out_data", sdata(), macc);
        if (mst == 2 && rdy) begin
            last_acc = sdata();
            n_acc++;
        end
        start = st; len = ln[7:0]; in_valid = v; mode = m; out_ready = rdy;
        for (int i = LAT; i > 0; i--) begin
            va[i] = va[i-1]; ma[i] = ma[i-1]; pa[i] = pa[i-1];
        end
        va[0] = v; ma[0] = m; pa[0] = pv;
        p = pa[LAT];
        @(posedge clk);
        case (mst)
            0: if (st) begin
                mst = 1; macc = 0; mcnt = 0; movf = 0;
                mneed = (ln % 256 == 0) ? 256 : ln % 256;
            end
            1: if (va[LAT]) begin
                t = macc + sub_sum(ma[LAT], pa[LAT]);
`ifdef MFU_ACC_SAT_EN
                if (t > MAXV) begin t = MAXV; movf = 1; end
                if (t < MINV) begin t = MINV; movf = 1; end
`else
                t = (((t + HALF) % FULL) + FULL) % FULL - HALF;
`endif
                macc = t;
                mcnt++;
                if (mcnt == mneed) mst = 2;
            end
            default: if (rdy) mst = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic drain(input int hold, input bit rnd);
        int held;
        bit r;
        held = 0;
        for (int k = 0; k < 600 && mst != 0; k++) begin
            r = rnd ? bit'($urandom_range(1)) : (mst == 2 && held >= hold);
            if (mst == 2 && !r) held++;
            step(0, 0, 0, 2'd0, 16'd0, r);
        end
        chk("drain_done", longint'(mst), 0);
    endtask

    task automatic job(input int ln, input logic [1:0] m, input int hold);
        int a0;
        a0 = n_acc;
        step(1, ln, 0, 2'd0, 16'd0, 1);
        foreach (prods[i]) step(0, 0, 1, m, prods[i], 1);
        drain(hold, 0);
        chk("pulses", longint'(n_acc - a0), 1);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_data", sdata(), 0);
        model_clear();
        start = 0; in_valid = 0; mode = 0; p = 0; out_ready = 0; len = 0;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        int ln, need, iss;
        bit v;
        logic [1:0] m;
        n_acc = 0;
        last_acc = 0;
        model_clear();
        start = 0; in_valid = 0; mode = 0; p = 0; out_ready = 0; len = 0;
        nrst = 1'b1;
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 3; k++) step(0, 0, 0, 2'd0, 16'd0, 1);

        prods = '{16'd100, 16'hFFEC, 16'd7, 16'd3};
        job(4, 2'd0, 0);
        chk("r034", last_acc, 90);

        prods = '{16'hFF02, 16'h0303};
        job(2, 2'd1, 0);
        chk("r035", last_acc, 7);

        prods = '{16'hF1F1};
        job(1, 2'd2, 0);
        chk("r036", last_acc, 0);

        prods = {};
        for (int i = 0; i < 256; i++) prods.push_back(16'd1);
        job(0, 2'd0, 5);
        chk("r037", last_acc, 256);

        step(1, 8, 0, 2'd0, 16'd0, 1);
        for (int i = 0; i < 3 + LAT; i++) step(0, 0, i < 3, 2'd0, 16'd9, 1);
        @(negedge clk);
        do_reset();
        prods = '{16'd5, 16'd5};
        job(2, 2'd0, 0);
        chk("r038", last_acc, 10);

        prods = {};
        for (int i = 0; i < 20; i++) prods.push_back(16'd32767);
        job(20, 2'd0, 0);
`ifdef MFU_ACC_SAT_EN
        chk("r039", last_acc, 524287);
        chk("r039_ovf", longint'(movf), 1);
`else
        chk("r039", last_acc, -393236);
`endif

        for (int j = 0; j < 30; j++) begin
            ln = (j == 7) ? 0 : int'($urandom_range(24, 1));
            need = (ln == 0) ? 256 : ln;
            m = 2'($urandom_range(3));
            v = bit'($urandom_range(1));
            iss = v ? 1 : 0;
            step(1, ln, v, m, 16'($urandom), 1);
            for (int k = 0; k < 2000 && iss < need; k++) begin
                v = ($urandom_range(9) < 7);
                if (v) iss++;
                step(($urandom_range(3) == 0), int'($urandom_range(255)),
                     v, m, 16'($urandom), 1);
            end
            if ($urandom_range(2) == 0)
                step(0, 0, 1, m, 16'($urandom), 0);
            drain(0, 1);
            step(0, 0, 0, 2'd0, 16'd0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mfu_acc_drain.md
MFU_ACC_DRAIN -- requirements
Module: mfu_acc_drain

Interface
REQ-001 Parameter LAT, default 1: mFU input-to-product latency in cycles, range 1..4.
REQ-002 Parameter ACC_W, default 32: accumulator and result width, range 20..48.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 nrst  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins a dot-product job.
REQ-006 len  input  8  products per job, sampled with start; 0 means 256.
REQ-007 in_valid  input  1  operands a/b/mode are presented to mFU this cycle.
REQ-008 mode  input  2  precision mode presented to mFU this cycle.
REQ-009 p  input  16  signed mFU product, valid LAT cycles after its operands.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  ACC_W  signed accumulated result.
REQ-013 busy  output  1  high in RUN or DONE.
REQ-014 ovf  output  1  sticky overflow flag for the current job.

Function
REQ-015 A LAT-deep shift register shall delay in_valid and mode so that v_d/mode_d align with p.
REQ-016 Sub-product sum S shall depend on mode_d:
  - 0: p as one signed 16-bit value.
  - 1: sign-extended p[15:8] + p[7:0].
  - 2: sign-extended sum of the four signed nibbles.
  - 3: reserved; S=0 and the product still counts.
REQ-017 All sums shall be sign-extended to ACC_W before addition.
REQ-018 FSM states shall be IDLE, RUN and DONE.
REQ-019 IDLE->RUN on start. On this transition: acc=0, cnt=0, ovf=0, target=len (0 means 256).
REQ-020 In RUN, each cycle with v_d=1 shall add S to acc and increment cnt.
REQ-021 On the cycle cnt reaches target, the FSM shall go to DONE with out_data equal to the final acc, out_valid=1 from the next cycle.
REQ-022 In DONE, out_valid and out_data shall be held stable until out_valid&&out_ready; the FSM then returns to IDLE with out_valid=0 the next cycle.
REQ-023 start while busy shall be ignored.
REQ-024 v_d=1 in IDLE or DONE shall be discarded and neither counted nor accumulated.
REQ-025 Products issued in the cycle start is asserted shall be counted, because the delay line is not cleared.
REQ-026 Acceptance in DONE and start in the same cycle: start is ignored and one IDLE cycle is required.
REQ-027 Output latency: the last aligned product at edge N gives out_valid=1 after edge N+1.

Reset
REQ-028 nrst low shall immediately force: state=IDLE, acc=0, cnt=0, target=0, delay line=0, out_valid=0, out_data=0, busy=0, ovf=0.
REQ-029 Reset mid-job shall abandon the job with no result emitted.

Configuration
REQ-030 With MFU_ACC_SAT_EN defined, addition shall saturate to the signed ACC_W limits and set ovf on any clip; ovf stays set until the next start.
REQ-031 Without MFU_ACC_SAT_EN, addition shall wrap modulo 2^ACC_W, ovf shall be tied 0, and no saturation logic is built.

Structure
REQ-032 Shared package mfu_pkg shall hold:
  - mode enum MODE_8X8=0, MODE_4X4=1, MODE_2X2=2.
  - FSM state enum.
  - constant P_W=16.
REQ-033 Sub-module mfu_unpack shall be the combinational mode_d/p -> S sum; everything else stays in mfu_acc_drain.

Verification
REQ-034 Mode 0, len=4, products 100,-20,7,3 with out_ready=1 -> out_data=90, one out_valid pulse, then IDLE.
REQ-035 Mode 1, len=2, p=16'hFF02 then 16'h0303 -> S=1 then 6; out_data=7.
REQ-036 Mode 2, len=1, p=16'hF1F1 -> nibbles -1,1,-1,1; out_data=0.
REQ-037 len=0 with 256 products of +1 -> out_data=256; out_valid held 5 cycles with out_ready=0, then accepted once.
REQ-038 nrst pulsed low after 3 of 8 products -> all outputs 0 immediately; a new job of len=2 (5,5) -> 10.
REQ-039 ACC_W=20, MFU_ACC_SAT_EN, 20 products of 32767 -> out_data=524287 and ovf=1; without the macro -> wrapped value 655340-1048576=-393236 and ovf=0.
